// File: rtl/fft_pkg.sv
// Shared constants and twiddle helpers for the radix-4 16-point FFT datapath.
// Twiddles are held at Q2.30 and rounded to the caller's fraction width.
package fft_pkg;

    localparam int FFT_N = 16;
    localparam int TW_FB = 30;

    localparam int Q30_ONE   = 1 << 30;
    localparam int Q30_COS_1 = 992008094;  // cos(pi/8)
    localparam int Q30_COS_2 = 759250125;  // cos(pi/4)
    localparam int Q30_COS_3 = 410903207;  // cos(3pi/8)

    function automatic logic [3:0] tw_exp(input logic [3:0] m);
        return {2'b00, m[3:2]} * {2'b00, m[1:0]};
    endfunction

    // cos(k*pi/8) for k = 0..15, i.e. cos(2*pi*k/16)
    function automatic int cos_q30(input logic [3:0] k);
        int v;
        case (k)
            4'd0:    v = Q30_ONE;
            4'd1:    v = Q30_COS_1;
            4'd2:    v = Q30_COS_2;
            4'd3:    v = Q30_COS_3;
            4'd4:    v = 0;
            4'd5:    v = -Q30_COS_3;
            4'd6:    v = -Q30_COS_2;
            4'd7:    v = -Q30_COS_1;
            4'd8:    v = -Q30_ONE;
            4'd9:    v = -Q30_COS_1;
            4'd10:   v = -Q30_COS_2;
            4'd11:   v = -Q30_COS_3;
            4'd12:   v = 0;
            4'd13:   v = Q30_COS_3;
            4'd14:   v = Q30_COS_2;
            4'd15:   v = Q30_COS_1;
            default: v = 0;
        endcase
        return v;
    endfunction

    // Round to nearest Q2.fb; valid for fb < TW_FB.
    function automatic int tw_quant(input int v, input int fb);
        return (v + (1 <<< (TW_FB - 1 - fb))) >>> (TW_FB - fb);
    endfunction

    function automatic int tw_re(input logic [3:0] e, input int fb);
        return tw_quant(cos_q30(e), fb);
    endfunction

    // -sin(theta) = -cos(theta - pi/2); the 4-bit subtract wraps mod 16.
    function automatic int tw_im(input logic [3:0] e, input int fb);
        return tw_quant(-cos_q30(e - 4'd4), fb);
    endfunction

endpackage

// File: rtl/Multiplier.sv
// Unsigned N x N combinational multiplier using radix-4 Booth recoding.
// The accumulator is exactly 2N bits: the true product always fits, so modular sums are exact.
module Multiplier #(
    parameter int N = 16
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] p
);

    // One extra digit so the top recoding group of an unsigned operand is non-negative.
    localparam int K = N / 2 + 1;

    logic [N+2:0]   bx;
    logic [2*N-1:0] a_ext;
    logic [2*N-1:0] pp;
    logic [2*N-1:0] acc;

    always_comb begin
        bx    = {2'b00, b, 1'b0};
        a_ext = {{N{1'b0}}, a};
        pp    = '0;
        acc   = '0;
        for (int i = 0; i < K; i++) begin
            case (bx[2*i +: 3])
                3'b001, 3'b010: pp = a_ext;
                3'b011:         pp = a_ext << 1;
                3'b100:         pp = -(a_ext << 1);
                3'b101, 3'b110: pp = -a_ext;
                default:        pp = '0;
            endcase
            acc = acc + (pp << (2 * i));
        end
        p = acc;
    end

endmodule

// File: rtl/twiddle_rotator.sv
// Inter-stage twiddle rotation for the 16-point radix-4 FFT: x * W16^e with e = m[3:2]*m[1:0].
// Two pipeline stages: signed products, then combine / round half-up / saturate.
module twiddle_rotator
    import fft_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sof,
    input  logic signed [DW-1:0] in_re,
    input  logic signed [DW-1:0] in_im,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic signed [DW-1:0] out_re,
    output logic signed [DW-1:0] out_im,
    output logic                 sync_err
);

    localparam int PW = 2 * DW + 1;
    localparam int SW = 2 * DW + 2;
    localparam logic signed [SW-1:0] RND     = SW'(1) << (DW - 3);
    localparam logic signed [SW-1:0] SAT_MAX = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    function automatic logic [DW-1:0] mag(input logic signed [DW-1:0] v);
        // -(-2^(DW-1)) wraps to the same bit pattern, which reads correctly as unsigned 2^(DW-1).
        return v[DW-1] ? DW'(-v) : v;
    endfunction

    function automatic logic signed [PW-1:0] apply_sign(input logic [2*DW-1:0] mg, input logic neg);
        logic signed [PW-1:0] t;
        t = {1'b0, mg};
        return neg ? -t : t;
    endfunction

    function automatic logic signed [DW-1:0] sat(input logic signed [SW-1:0] v);
        if (v > SAT_MAX) return {1'b0, {(DW-1){1'b1}}};
        if (v < SAT_MIN) return {1'b1, {(DW-1){1'b0}}};
        return v[DW-1:0];
    endfunction

    // Handshake: a port transfers when valid & ready on the same edge. A stage
    // advances when it is empty or the stage downstream advances; valid data
    // holds still otherwise, so out_ready=0 stalls both stages without loss.
    logic s1_valid, s2_valid;
    logic s1_en, s2_en, in_fire;

    assign s2_en     = ~s2_valid | out_ready;
    assign s1_en     = ~s1_valid | s2_en;
    assign in_ready  = s1_en;
    assign in_fire   = in_valid & s1_en;
    assign out_valid = s2_valid;

    // Index and twiddle selection; a start-of-frame sample is forced to index 0.
    logic [3:0] idx;
    logic [3:0] m;
    logic [3:0] e;
    logic signed [DW-1:0] wr, wi;

    assign m  = in_sof ? 4'd0 : idx;
    assign e  = tw_exp(m);
    assign wr = DW'(tw_re(e, DW - 2));
    assign wi = DW'(tw_im(e, DW - 2));

    logic [DW-1:0]   mag_xr, mag_xi, mag_wr, mag_wi;
    logic [2*DW-1:0] mag_rr, mag_ii, mag_ri, mag_ir;

    assign mag_xr = mag(in_re);
    assign mag_xi = mag(in_im);
    assign mag_wr = mag(wr);
    assign mag_wi = mag(wi);

    Multiplier #(.N(DW)) u_mul_rr (.a(mag_xr), .b(mag_wr), .p(mag_rr));
    Multiplier #(.N(DW)) u_mul_ii (.a(mag_xi), .b(mag_wi), .p(mag_ii));
    Multiplier #(.N(DW)) u_mul_ri (.a(mag_xr), .b(mag_wi), .p(mag_ri));
    Multiplier #(.N(DW)) u_mul_ir (.a(mag_xi), .b(mag_wr), .p(mag_ir));

    logic signed [PW-1:0] prod_rr, prod_ii, prod_ri, prod_ir;

    assign prod_rr = apply_sign(mag_rr, in_re[DW-1] ^ wr[DW-1]);
    assign prod_ii = apply_sign(mag_ii, in_im[DW-1] ^ wi[DW-1]);
    assign prod_ri = apply_sign(mag_ri, in_re[DW-1] ^ wi[DW-1]);
    assign prod_ir = apply_sign(mag_ir, in_im[DW-1] ^ wr[DW-1]);

    // Stage 1: products, frame-position bookkeeping.
    logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
    logic                 s1_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            p_rr     <= '0;
            p_ii     <= '0;
            p_ri     <= '0;
            p_ir     <= '0;
            idx      <= 4'd0;
            sync_err <= 1'b0;
        end else begin
            if (s1_en) s1_valid <= in_valid;
            if (in_fire) begin
                p_rr    <= prod_rr;
                p_ii    <= prod_ii;
                p_ri    <= prod_ri;
                p_ir    <= prod_ir;
                s1_last <= (m == 4'(FFT_N - 1));
                idx     <= m + 4'd1;
                if (in_sof && idx != 4'd0) sync_err <= 1'b1;
            end
        end
    end

    // Stage 2: complex combine, round half-up, saturate.
    logic signed [SW-1:0] re_sum, im_sum, re_rnd, im_rnd;

    always_comb begin
        re_sum = {p_rr[PW-1], p_rr} - {p_ii[PW-1], p_ii};
        im_sum = {p_ri[PW-1], p_ri} + {p_ir[PW-1], p_ir};
        re_rnd = (re_sum + RND) >>> (DW - 2);
        im_rnd = (im_sum + RND) >>> (DW - 2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            out_re   <= '0;
            out_im   <= '0;
            out_last <= 1'b0;
        end else if (s2_en) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_re   <= sat(re_rnd);
                out_im   <= sat(im_rnd);
                out_last <= s1_last;
            end
        end
    end

endmodule

// File: tb/tb_twiddle_rotator.sv
// Directed bench for twiddle_rotator: passthrough, rotation, backpressure, resync and reset.
module tb_twiddle_rotator;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic               in_sof = 1'b0;
    logic signed [15:0] in_re = '0;
    logic signed [15:0] in_im = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic               out_last;
    logic signed [15:0] out_re;
    logic signed [15:0] out_im;
    logic               sync_err;

    int n_vec = 0;
    int n_err = 0;

    logic [32:0] exp_q[$];

    // W16^e for e = 0..9 at Q2.14, hand-rounded
    int twr [10] = '{16384, 15137, 11585, 6270, 0, -6270, -11585, -15137, -16384, -15137};
    int twi [10] = '{0, -6270, -11585, -15137, -16384, -15137, -11585, -6270, 0, 6270};

    // indices 4..15 of the first frame: inputs and hand-computed outputs
    int rot_xr [12] = '{-32768, 16384, 16384, 1, 100, 0, -32768, 16384, 7, 0, -16384, 16384};
    int rot_xi [12] = '{32767, 0, 16384, 1, -100, 16384, 100, 0, -8, 16384, 0, 0};
    int rot_er [12] = '{-32768, 15137, 23170, 1, 100, 11585, 100, -11585, 7, 15137, 11585, -15137};
    int rot_ei [12] = '{32767, -6270, 0, -1, -100, 11585, 32767, -11585, -8, 6270, 11585, 6270};

    twiddle_rotator #(.DW(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sof    (in_sof),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_re    (out_re),
        .out_im    (out_im),
        .sync_err  (sync_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    function automatic logic [32:0] model_rot(input int m, input int xr, input int xi);
        int     e;
        longint re, im;
        e  = (m / 4) * (m % 4);
        re = longint'(xr) * twr[e] - longint'(xi) * twi[e];
        im = longint'(xr) * twi[e] + longint'(xi) * twr[e];
        re = (re + 8192) >>> 14;
        im = (im + 8192) >>> 14;
        if (re > 32767) re = 32767;
        if (re < -32768) re = -32768;
        if (im > 32767) im = 32767;
        if (im < -32768) im = -32768;
        return {(m == 15), re[15:0], im[15:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_re    = '0;
        in_im    = '0;
    endtask

    // Caller guarantees in_ready is high for this cycle.
    task automatic send_sample(input int re, input int im, input logic sof);
        in_valid = 1'b1;
        in_sof   = sof;
        in_re    = 16'(re);
        in_im    = 16'(im);
        tick();
        drive_idle();
    endtask

    task automatic test_reset();
        drive_idle();
        out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
        n_vec++; if (out_re !== 16'sd0) begin n_err++; $display("FAIL reset out_re: got %0d want 0", out_re); end
        n_vec++; if (out_im !== 16'sd0) begin n_err++; $display("FAIL reset out_im: got %0d want 0", out_im); end
        n_vec++; if (out_last !== 1'b0) begin n_err++; $display("FAIL reset out_last: got %b want 0", out_last); end
        n_vec++; if (sync_err !== 1'b0) begin n_err++; $display("FAIL reset sync_err: got %b want 0", sync_err); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_passthrough();
        int pre [4] = '{1234, -1, 32767, 0};
        int pim [4] = '{-567, 1, -32768, 0};
        out_ready = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            if (i < 4) begin
                in_valid = 1'b1;
                in_sof   = (i == 0);
                in_re    = 16'(pre[i]);
                in_im    = 16'(pim[i]);
            end else begin
                drive_idle();
            end
            tick();
            if (i == 0) begin
                n_vec++;
                if (out_valid !== 1'b0) begin n_err++; $display("FAIL passthrough latency: got out_valid=%b want 0 one cycle after accept", out_valid); end
            end else begin
                n_vec++;
                if (out_valid !== 1'b1 || out_re !== 16'(pre[i-1]) || out_im !== 16'(pim[i-1]) || out_last !== 1'b0) begin
                    n_err++;
                    $display("FAIL passthrough m=%0d: got v=%b (%0d,%0d) last=%b want v=1 (%0d,%0d) last=0",
                             i - 1, out_valid, out_re, out_im, out_last, pre[i-1], pim[i-1]);
                end
            end
        end
        tick();
    endtask

    task automatic test_rotation();
        out_ready = 1'b1;
        for (int i = 0; i <= 12; i++) begin
            if (i < 12) begin
                in_valid = 1'b1;
                in_sof   = 1'b0;
                in_re    = 16'(rot_xr[i]);
                in_im    = 16'(rot_xi[i]);
            end else begin
                drive_idle();
            end
            tick();
            if (i > 0) begin
                n_vec++;
                if (out_valid !== 1'b1 || out_re !== 16'(rot_er[i-1]) || out_im !== 16'(rot_ei[i-1]) ||
                    out_last !== (i == 12)) begin
                    n_err++;
                    $display("FAIL rotation m=%0d: got v=%b (%0d,%0d) last=%b want v=1 (%0d,%0d) last=%b",
                             i + 3, out_valid, out_re, out_im, out_last, rot_er[i-1], rot_ei[i-1], (i == 12));
                end
            end
        end
        tick();
    endtask

    task automatic test_backpressure();
        int sent = 0;
        int cyc = 0;
        int xr, xi;
        logic exp_ready;
        logic [32:0] got;
        exp_q.delete();
        while ((sent < 64 || exp_q.size() > 0) && cyc < 2000) begin
            out_ready = 1'($urandom_range(0, 1));
            xr = ((sent * 2749) % 60001) - 30000;
            xi = 25000 - ((sent * 1931) % 50001);
            if (sent < 64) begin
                in_valid = 1'b1;
                in_sof   = (sent % 16 == 0);
                in_re    = 16'(xr);
                in_im    = 16'(xi);
            end else begin
                drive_idle();
            end
            #1;
            exp_ready = !(exp_q.size() == 2 && !out_ready);
            n_vec++;
            if (in_ready !== exp_ready) begin
                n_err++;
                $display("FAIL backpressure in_ready cyc=%0d: got %b want %b", cyc, in_ready, exp_ready);
            end
            if (out_valid === 1'b1) begin
                got = {out_last, out_re, out_im};
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL backpressure spurious output cyc=%0d: got %h want nothing", cyc, got);
                end else if (got !== exp_q[0]) begin
                    n_err++;
                    $display("FAIL backpressure data cyc=%0d: got %h want %h", cyc, got, exp_q[0]);
                end
                if (out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model_rot(sent % 16, xr, xi));
                sent++;
            end
            tick();
            cyc++;
        end
        drive_idle();
        out_ready = 1'b1;
        n_vec++;
        if (sent != 64 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL backpressure completion: got sent=%0d pending=%0d want sent=64 pending=0", sent, exp_q.size());
        end
        n_vec++;
        if (sync_err !== 1'b0) begin n_err++; $display("FAIL backpressure sync_err: got %b want 0", sync_err); end
    endtask

    task automatic test_sync();
        out_ready = 1'b1;
        send_sample(0, 0, 1'b1);
        for (int i = 0; i < 6; i++) send_sample(0, 0, 1'b0);
        repeat (3) tick();
        n_vec++;
        if (sync_err !== 1'b0) begin n_err++; $display("FAIL sync sof at idx0: got sync_err=%b want 0", sync_err); end
        send_sample(16384, 0, 1'b1);
        n_vec++;
        if (sync_err !== 1'b1) begin n_err++; $display("FAIL sync sof at idx7: got sync_err=%b want 1", sync_err); end
        tick();
        n_vec++;
        if (out_valid !== 1'b1 || out_re !== 16'sd16384 || out_im !== 16'sd0 || out_last !== 1'b0) begin
            n_err++;
            $display("FAIL sync resync sample: got v=%b (%0d,%0d) last=%b want v=1 (16384,0) last=0", out_valid, out_re, out_im, out_last);
        end
        for (int i = 0; i < 4; i++) send_sample(0, 0, 1'b0);
        send_sample(16384, 0, 1'b0);
        tick();
        n_vec++;
        if (out_valid !== 1'b1 || out_re !== 16'sd15137 || out_im !== -16'sd6270) begin
            n_err++;
            $display("FAIL sync m5 after resync: got v=%b (%0d,%0d) want v=1 (15137,-6270)", out_valid, out_re, out_im);
        end
        repeat (3) tick();
        n_vec++;
        if (sync_err !== 1'b1) begin n_err++; $display("FAIL sync sticky: got sync_err=%b want 1", sync_err); end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) send_sample(0, 0, 1'b0);
        repeat (2) tick();
        out_ready = 1'b0;
        send_sample(16384, 0, 1'b0);
        send_sample(5, 5, 1'b0);
        n_vec++;
        if (out_valid !== 1'b1 || out_re !== 16'sd11585 || out_im !== -16'sd11585) begin
            n_err++;
            $display("FAIL midstream m9 held: got v=%b (%0d,%0d) want v=1 (11585,-11585)", out_valid, out_re, out_im);
        end
        n_vec++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL midstream full in_ready: got %b want 0", in_ready); end
        out_ready = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL midstream comb in_ready: got %b want 1", in_ready); end
        out_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || out_re !== 16'sd0 || out_im !== 16'sd0 || out_last !== 1'b0) begin
            n_err++;
            $display("FAIL midstream async reset: got v=%b (%0d,%0d) last=%b want v=0 (0,0) last=0", out_valid, out_re, out_im, out_last);
        end
        n_vec++;
        if (sync_err !== 1'b0) begin n_err++; $display("FAIL midstream sync_err clear: got %b want 0", sync_err); end
        #2 rst_n = 1'b1;
        tick();
        out_ready = 1'b1;
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL midstream discard: got out_valid=%b want 0", out_valid); end
        send_sample(16384, 0, 1'b0);
        tick();
        n_vec++;
        if (out_valid !== 1'b1 || out_re !== 16'sd16384 || out_im !== 16'sd0) begin
            n_err++;
            $display("FAIL midstream restart m0: got v=%b (%0d,%0d) want v=1 (16384,0)", out_valid, out_re, out_im);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_rotation();
        test_backpressure();
        test_sync();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
